// File: rtl/swc_ob_prio_queue.sv
// swc_ob_prio_queue
// Receive side of the page-transfer arbiter protocol at one output port.
// Offered page descriptors are acknowledged and stored in one FIFO per
// priority level. The head of the highest non-empty priority queue is then
// presented to the packet reader through a single output register.
//
// Acceptance takes two steps. The accept decision registers the descriptor
// and raises pta_ack_o. The queue write happens on the edge that ends the
// ack cycle. While ack is high no new accept is possible, so the occupancy
// counts are already up to date the next time an accept is evaluated.
module swc_ob_prio_queue #(
   parameter int g_page_addr_width  = 10,
   parameter int g_prio_width       = 3,
   parameter int g_queue_depth_log2 = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_n_i,
   input  logic                         pta_data_valid_i,
   input  logic [g_page_addr_width-1:0] pta_pageaddr_i,
   input  logic [g_prio_width-1:0]      pta_prio_i,
   output logic                         pta_ack_o,
   output logic                         rd_valid_o,
   output logic [g_page_addr_width-1:0] rd_pageaddr_o,
   output logic [g_prio_width-1:0]      rd_prio_o,
   input  logic                         rd_ack_i,
   output logic [2**g_prio_width-1:0]   queue_full_o,
   output logic                         empty_o
);

   localparam int c_num_q = 2**g_prio_width;
   localparam int c_depth = 2**g_queue_depth_log2;
   localparam logic [g_queue_depth_log2:0] c_full_cnt = (g_queue_depth_log2+1)'(c_depth);

   logic [g_page_addr_width-1:0]  mem    [c_num_q][c_depth];
   logic [g_queue_depth_log2-1:0] wr_ptr [c_num_q];
   logic [g_queue_depth_log2-1:0] rd_ptr [c_num_q];
   logic [g_queue_depth_log2:0]   cnt    [c_num_q];

   logic [g_page_addr_width-1:0]  pend_addr;
   logic [g_prio_width-1:0]       pend_prio;

   logic [c_num_q-1:0]            queue_nonempty;
   logic [c_num_q-1:0]            push_vec;
   logic [c_num_q-1:0]            pop_vec;
   logic                          accept;
   logic                          load_en;
   logic                          pop;
   logic                          sel_found;
   logic [g_prio_width-1:0]       sel_q;
   logic [g_page_addr_width-1:0]  head_addr;

   // Per-queue full/non-empty flags, derived from the registered counts only.
   always_comb begin
      queue_full_o   = '0;
      queue_nonempty = '0;
      for (int q = 0; q < c_num_q; q++) begin
         queue_full_o[q]   = (cnt[q] == c_full_cnt);
         queue_nonempty[q] = (cnt[q] != '0);
      end
   end

   // Accept when an offer is present, its queue has room and no ack is in flight.
   assign accept = pta_data_valid_i & ~queue_full_o[pta_prio_i] & ~pta_ack_o;

   // Pick the highest-numbered non-empty queue. Later iterations override earlier ones.
   always_comb begin
      sel_found = 1'b0;
      sel_q     = '0;
      for (int q = 0; q < c_num_q; q++) begin
         if (queue_nonempty[q]) begin
            sel_found = 1'b1;
            sel_q     = g_prio_width'(q);
         end
      end
   end

   assign head_addr = mem[sel_q][rd_ptr[sel_q]];
   assign load_en   = ~rd_valid_o | rd_ack_i;
   assign pop       = load_en & sel_found;

   // One-hot push (ack cycle, into the captured priority) and pop (output load) per queue.
   always_comb begin
      push_vec = '0;
      pop_vec  = '0;
      if (pta_ack_o) begin
         push_vec[pend_prio] = 1'b1;
      end
      if (pop) begin
         pop_vec[sel_q] = 1'b1;
      end
   end

   // Queue pointers and occupancy. A push and a pop on one queue leave the count unchanged.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int q = 0; q < c_num_q; q++) begin
            wr_ptr[q] <= '0;
            rd_ptr[q] <= '0;
            cnt[q]    <= '0;
         end
      end else begin
         for (int q = 0; q < c_num_q; q++) begin
            if (push_vec[q]) begin
               wr_ptr[q] <= wr_ptr[q] + 1'b1;
            end
            if (pop_vec[q]) begin
               rd_ptr[q] <= rd_ptr[q] + 1'b1;
            end
            if (push_vec[q] && !pop_vec[q]) begin
               cnt[q] <= cnt[q] + 1'b1;
            end else if (!push_vec[q] && pop_vec[q]) begin
               cnt[q] <= cnt[q] - 1'b1;
            end
         end
      end
   end

   // Descriptor storage. Contents are only meaningful below the count, so there is no reset.
   always_ff @(posedge clk_i) begin
      if (pta_ack_o) begin
         mem[pend_prio][wr_ptr[pend_prio]] <= pend_addr;
      end
   end

   // Ack pulse, descriptor capture, and the presented output register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pta_ack_o     <= 1'b0;
         pend_addr     <= '0;
         pend_prio     <= '0;
         rd_valid_o    <= 1'b0;
         rd_pageaddr_o <= '0;
         rd_prio_o     <= '0;
      end else begin
         pta_ack_o <= accept;
         if (accept) begin
            pend_addr <= pta_pageaddr_i;
            pend_prio <= pta_prio_i;
         end
         if (load_en) begin
            rd_valid_o <= sel_found;
            if (sel_found) begin
               rd_pageaddr_o <= head_addr;
               rd_prio_o     <= sel_q;
            end
         end
      end
   end

   assign empty_o = ~rd_valid_o & ~(|queue_nonempty);

endmodule

// File: tb/tb_swc_ob_prio_queue.sv
// Testbench for swc_ob_prio_queue: directed scenarios plus randomized
// traffic, checked against a queue-based reference model.
module tb_swc_ob_prio_queue;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       valid;
   logic [9:0] pageaddr;
   logic [2:0] prio;
   logic       rd_ack;
   logic       pta_ack_o;
   logic       rd_valid_o;
   logic [9:0] rd_pageaddr_o;
   logic [2:0] rd_prio_o;
   logic [7:0] queue_full_o;
   logic       empty_o;

   int checks = 0;
   int errors = 0;

   swc_ob_prio_queue dut (
      .clk_i            (clk),
      .rst_n_i          (rst_n),
      .pta_data_valid_i (valid),
      .pta_pageaddr_i   (pageaddr),
      .pta_prio_i       (prio),
      .pta_ack_o        (pta_ack_o),
      .rd_valid_o       (rd_valid_o),
      .rd_pageaddr_o    (rd_pageaddr_o),
      .rd_prio_o        (rd_prio_o),
      .rd_ack_i         (rd_ack),
      .queue_full_o     (queue_full_o),
      .empty_o          (empty_o)
   );

   always #5 clk = ~clk;

   // Reference model: one FIFO per priority, an in-flight ack with its
   // captured descriptor, and the presented descriptor.
   logic [9:0] mq [8][$];
   logic       m_ack;
   logic [9:0] m_pend_addr;
   logic [2:0] m_pend_prio;
   logic       m_valid;
   logic [9:0] m_addr;
   logic [2:0] m_prio;
   logic       m_cons;
   logic [9:0] m_cons_addr;

   logic [23:0] act_bundle;
   assign act_bundle = {pta_ack_o, rd_valid_o, rd_valid_o ? rd_pageaddr_o : 10'h0,
                        rd_valid_o ? rd_prio_o : 3'h0, queue_full_o, empty_o};

   function automatic logic [23:0] exp_bundle();
      logic [7:0] f;
      logic       e;
      f = '0;
      e = !m_valid;
      for (int p = 0; p < 8; p++) begin
         f[p] = (mq[p].size() == 16);
         if (mq[p].size() != 0) e = 1'b0;
      end
      return {m_ack, m_valid, m_valid ? m_addr : 10'h0, m_valid ? m_prio : 3'h0, f, e};
   endfunction

   task automatic model_clear();
      for (int p = 0; p < 8; p++) mq[p].delete();
      m_ack = 0; m_pend_addr = 0; m_pend_prio = 0;
      m_valid = 0; m_addr = 0; m_prio = 0; m_cons = 0; m_cons_addr = 0;
   endtask

   // Advance the model by one clock using the current inputs, then step the DUT.
   task automatic tick();
      logic acc;
      int   sel;
      acc = valid && (mq[prio].size() < 16) && !m_ack;
      m_cons = 0;
      if (rd_ack && m_valid) begin
         m_cons      = 1;
         m_cons_addr = m_addr;
      end
      if (!m_valid || rd_ack) begin
         sel = -1;
         for (int p = 7; p >= 0; p--)
            if (sel < 0 && mq[p].size() > 0) sel = p;
         if (sel >= 0) begin
            m_addr  = mq[sel].pop_front();
            m_prio  = sel[2:0];
            m_valid = 1;
         end else begin
            m_valid = 0;
         end
      end
      if (m_ack) mq[m_pend_prio].push_back(m_pend_addr);
      m_ack = acc;
      if (acc) begin
         m_pend_addr = pageaddr;
         m_pend_prio = prio;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      valid = 0; pageaddr = 0; prio = 0; rd_ack = 0;
      rst_n = 0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
   endtask

   task automatic test_reset();
      valid = 0; pageaddr = 0; prio = 0; rd_ack = 0;
      rst_n = 0;
      #1;
      checks++;
      if ({pta_ack_o, rd_valid_o, rd_pageaddr_o, rd_prio_o, queue_full_o, empty_o} !== 24'h000001) begin
         errors++;
         $display("FAIL reset_values act=%h exp=%h",
                  {pta_ack_o, rd_valid_o, rd_pageaddr_o, rd_prio_o, queue_full_o, empty_o}, 24'h000001);
      end
      do_reset();
      checks++;
      if (act_bundle !== exp_bundle()) begin
         errors++;
         $display("FAIL reset_release act=%h exp=%h", act_bundle, exp_bundle());
      end
   endtask

   task automatic test_single_offer();
      rd_ack = 0; valid = 1; pageaddr = 10'h00A; prio = 3'd3;
      tick();
      checks++;
      if (pta_ack_o !== 1'b1) begin
         errors++; $display("FAIL single_ack act=%b exp=1", pta_ack_o);
      end
      valid = 0;
      tick();
      checks++;
      if ({pta_ack_o, rd_valid_o} !== 2'b00) begin
         errors++; $display("FAIL single_ack_cycle2 act=%b exp=00", {pta_ack_o, rd_valid_o});
      end
      tick();
      checks++;
      if ({rd_valid_o, rd_pageaddr_o, rd_prio_o} !== {1'b1, 10'h00A, 3'd3}) begin
         errors++;
         $display("FAIL single_present act=%h exp=%h", {rd_valid_o, rd_pageaddr_o, rd_prio_o}, {1'b1, 10'h00A, 3'd3});
      end
      rd_ack = 1;
      tick();
      rd_ack = 0;
      checks++;
      if ({rd_valid_o, empty_o} !== 2'b01) begin
         errors++; $display("FAIL single_consume act=%b exp=01", {rd_valid_o, empty_o});
      end
      checks++;
      if (act_bundle !== exp_bundle()) begin
         errors++; $display("FAIL single_model act=%h exp=%h", act_bundle, exp_bundle());
      end
   endtask

   task automatic test_priority();
      logic [9:0] a [3];
      logic [2:0] p [3];
      logic [9:0] exp_order [3];
      int n;
      logic got;
      a = '{10'd11, 10'd13, 10'd17};
      p = '{3'd1, 3'd3, 3'd7};
      exp_order = '{10'd11, 10'd17, 10'd13};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         valid = 1; pageaddr = a[i]; prio = p[i];
         got = 0;
         for (int c = 0; c < 20 && !got; c++) begin
            tick();
            checks++;
            if (act_bundle !== exp_bundle()) begin
               errors++; $display("FAIL prio_load act=%h exp=%h", act_bundle, exp_bundle());
            end
            if (m_ack) got = 1;
         end
         if (!got) begin
            errors++; $display("FAIL prio_ack_timeout act=0 exp=1");
         end
         valid = 0;
      end
      repeat (3) tick();
      rd_ack = 1;
      n = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         checks++;
         if (act_bundle !== exp_bundle()) begin
            errors++; $display("FAIL prio_drain act=%h exp=%h", act_bundle, exp_bundle());
         end
         if (m_cons) begin
            checks++;
            if (n >= 3 || rd_pageaddr_o === 10'h3FF || m_cons_addr !== exp_order[n]) begin
               errors++;
               $display("FAIL prio_order idx=%0d act=%0d exp=%0d", n, m_cons_addr, (n < 3) ? exp_order[n] : 10'h0);
            end
            n++;
         end
      end
      rd_ack = 0;
      checks++;
      if (n != 3) begin
         errors++; $display("FAIL prio_count act=%0d exp=3", n);
      end
   endtask

   task automatic test_full();
      int acks;
      do_reset();
      rd_ack = 0; valid = 1; prio = 3'd5; pageaddr = 10'd0;
      acks = 0;
      for (int c = 0; c < 80 && acks < 17; c++) begin
         tick();
         checks++;
         if (act_bundle !== exp_bundle()) begin
            errors++; $display("FAIL full_fill act=%h exp=%h", act_bundle, exp_bundle());
         end
         if (pta_ack_o === 1'b1) begin
            acks++;
            pageaddr = pageaddr + 10'd1;
         end
      end
      repeat (2) tick();
      checks++;
      if (acks != 17 || queue_full_o[5] !== 1'b1) begin
         errors++; $display("FAIL full_flag acks=%0d full5=%b exp acks=17 full5=1", acks, queue_full_o[5]);
      end
      acks = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (pta_ack_o === 1'b1) acks++;
      end
      checks++;
      if (acks != 0) begin
         errors++; $display("FAIL full_blocked acks=%0d exp=0", acks);
      end
      rd_ack = 1;
      tick();
      rd_ack = 0;
      acks = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         checks++;
         if (act_bundle !== exp_bundle()) begin
            errors++; $display("FAIL full_release act=%h exp=%h", act_bundle, exp_bundle());
         end
         if (pta_ack_o === 1'b1) begin
            acks++;
            valid = 0;
         end
      end
      checks++;
      if (acks != 1) begin
         errors++; $display("FAIL full_single_ack acks=%0d exp=1", acks);
      end
   endtask

   task automatic test_wrap();
      int sent;
      int recv;
      do_reset();
      sent = 0; recv = 0;
      valid = 1; prio = 3'd2; pageaddr = 10'd100;
      for (int c = 0; c < 2000 && recv < 40; c++) begin
         rd_ack = 1'($urandom % 2);
         tick();
         checks++;
         if (act_bundle !== exp_bundle()) begin
            errors++; $display("FAIL wrap_step act=%h exp=%h", act_bundle, exp_bundle());
         end
         if (m_cons) begin
            checks++;
            if (m_cons_addr !== 10'(100 + recv)) begin
               errors++; $display("FAIL wrap_order idx=%0d act=%0d exp=%0d", recv, m_cons_addr, 100 + recv);
            end
            recv++;
         end
         if (m_ack) begin
            sent++;
            pageaddr = 10'(100 + sent);
            if (sent >= 40) valid = 0;
         end
      end
      rd_ack = 0; valid = 0;
      checks++;
      if (recv != 40 || sent != 40) begin
         errors++; $display("FAIL wrap_count sent=%0d recv=%0d exp=40", sent, recv);
      end
   endtask

   task automatic test_held_valid();
      int acks;
      int recv;
      do_reset();
      rd_ack = 0; valid = 1; pageaddr = 10'h155; prio = 3'd4;
      acks = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         checks++;
         if (act_bundle !== exp_bundle()) begin
            errors++; $display("FAIL held_step act=%h exp=%h", act_bundle, exp_bundle());
         end
         if (pta_ack_o === 1'b1) acks++;
      end
      valid = 0;
      checks++;
      if (acks != 5) begin
         errors++; $display("FAIL held_acks act=%0d exp=5", acks);
      end
      rd_ack = 1;
      recv = 0;
      for (int c = 0; c < 10; c++) begin
         if (rd_valid_o === 1'b1) recv++;
         tick();
      end
      rd_ack = 0;
      checks++;
      if (recv != 5 || empty_o !== 1'b1) begin
         errors++; $display("FAIL held_entries act=%0d empty=%b exp=5 empty=1", recv, empty_o);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         rd_ack = (c < 300) ? (($urandom % 5) == 0) : (($urandom % 4) != 0);
         if (!valid && ($urandom % 3) != 0) begin
            valid = 1; pageaddr = 10'($urandom);
            prio = (($urandom % 2) == 0) ? 3'd6 : 3'($urandom);
         end
         tick();
         checks++;
         if (act_bundle !== exp_bundle()) begin
            errors++; $display("FAIL random_step cyc=%0d act=%h exp=%h", c, act_bundle, exp_bundle());
         end
         if (m_ack) begin
            valid = 1'($urandom % 2);
            pageaddr = 10'($urandom);
            prio = 3'($urandom);
         end
      end
      valid = 0; rd_ack = 0;
   endtask

   task automatic test_reset_mid();
      logic [2:0] pl [6];
      logic got;
      pl = '{3'd0, 3'd4, 3'd4, 3'd2, 3'd7, 3'd1};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         valid = 1; pageaddr = 10'(200 + i); prio = pl[i];
         got = 0;
         for (int c = 0; c < 20 && !got; c++) begin
            tick();
            if (m_ack) got = 1;
         end
         checks++;
         if (!got || act_bundle !== exp_bundle()) begin
            errors++; $display("FAIL rstmid_fill act=%h exp=%h", act_bundle, exp_bundle());
         end
         valid = 0;
      end
      repeat (3) tick();
      checks++;
      if (rd_valid_o !== 1'b1 || act_bundle !== exp_bundle()) begin
         errors++; $display("FAIL rstmid_loaded act=%h exp=%h", act_bundle, exp_bundle());
      end
      #2;
      rst_n = 0;
      #1;
      checks++;
      if ({pta_ack_o, rd_valid_o, rd_pageaddr_o, rd_prio_o, queue_full_o, empty_o} !== 24'h000001) begin
         errors++;
         $display("FAIL rstmid_async act=%h exp=%h",
                  {pta_ack_o, rd_valid_o, rd_pageaddr_o, rd_prio_o, queue_full_o, empty_o}, 24'h000001);
      end
      do_reset();
      test_single_offer();
   endtask

   initial begin
      model_clear();
      test_reset();
      test_single_offer();
      test_priority();
      test_full();
      test_wrap();
      test_held_valid();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
